// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller.
//
// Turns per-stage stall / release / flush requests into registered per-stage
// hold and flush commands (one cycle from request to command).
//   flush_req  : highest set index k>=1 flushes stages 0..k-1 for FLUSH_HOLD cycles
//   release_req: any bit at or above the current stall source ends a stall
//   stall_req  : highest set index j holds stages 0..j until released (sticky)
// Priority: flush, then release, then stall.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   stall_req/release_req/flush_req  [NSTAGE-1:0] per-stage requests
//   stall, flush                  [NSTAGE-1:0] registered per-stage commands
//   busy                          registered, high while not in RUN
//   timeout                       registered one-cycle watchdog pulse
//
// Build option: define PIPE_CTRL_STALL_TIMEOUT_EN to add a TIMEOUT_W-bit
// watchdog that forces a stall back to RUN after 2^TIMEOUT_W-1 cycles. Without
// it, timeout is tied low and a stall is held until released.
module pipe_ctrl #(
    parameter int NSTAGE     = 5,
    parameter int FLUSH_HOLD = 1,
    parameter int TIMEOUT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic [NSTAGE-1:0] release_req,
    input  logic [NSTAGE-1:0] flush_req,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              busy,
    output logic              timeout
);

    localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD - 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t        state;
    logic [IW-1:0] src;     // stage that owns the current stall
    logic [IW-1:0] fk;      // depth of the current flush (stages 0..fk-1)
    logic [3:0]    hold;    // remaining flush cycles minus one

`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
    // Fires on the last of 2^TIMEOUT_W-1 stall cycles (counter starts at 0).
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
    logic [TIMEOUT_W-1:0] wd;
`endif

    // Request decode: highest set index of each request vector, the masks it
    // implies, and whether any release bit reaches the stall source.
    logic [IW-1:0]     f_hi, s_hi;
    logic [NSTAGE-1:0] f_mask, s_mask;
    logic              f_any, s_any, rel_hit;

    always_comb begin
        f_hi    = '0;
        s_hi    = '0;
        rel_hit = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (flush_req[i]) f_hi = IW'(i);
            if (stall_req[i]) s_hi = IW'(i);
            if (release_req[i] && (IW'(i) >= src)) rel_hit = 1'b1;
        end
        for (int i = 0; i < NSTAGE; i++) begin
            f_mask[i] = (IW'(i) <  f_hi);
            s_mask[i] = (IW'(i) <= s_hi);
        end
        // f_hi is zero both for "no request" and "only bit 0": both are no-ops.
        f_any = (f_hi != '0);
        s_any = |stall_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            stall <= '0;
            flush <= '0;
            busy  <= 1'b0;
            src   <= '0;
            fk    <= '0;
            hold  <= '0;
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
            wd      <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            // A flush wins from any state; inside FLUSH only a deeper one counts.
            if (f_any && ((state != FLUSH) || (f_hi > fk))) begin
                state <= FLUSH;
                flush <= f_mask;
                stall <= '0;
                fk    <= f_hi;
                hold  <= HOLD_INIT;
                busy  <= 1'b1;
            end else begin
                case (state)
                    FLUSH: begin
                        if (hold == 4'd0) begin
                            state <= RUN;
                            flush <= '0;
                            busy  <= 1'b0;
                        end else begin
                            hold <= hold - 4'd1;
                        end
                    end
                    STALL: begin
                        if (rel_hit) begin
                            state <= RUN;
                            stall <= '0;
                            busy  <= 1'b0;
                        end else if (s_any && (s_hi > src)) begin
                            stall <= s_mask;
                            src   <= s_hi;
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
                            wd    <= '0;
`endif
                        end
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
                        else if (wd == WD_LAST) begin
                            state   <= RUN;
                            stall   <= '0;
                            busy    <= 1'b0;
                            timeout <= 1'b1;
                        end else begin
                            wd <= wd + TIMEOUT_W'(1);
                        end
`endif
                    end
                    RUN: begin
                        // Release in RUN has nothing to act on.
                        if (s_any) begin
                            state <= STALL;
                            stall <= s_mask;
                            src   <= s_hi;
                            busy  <= 1'b1;
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
                            wd    <= '0;
`endif
                        end
                    end
                    default: begin
                        state <= RUN;
                        stall <= '0;
                        flush <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef PIPE_CTRL_STALL_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- bench for pipe_ctrl (NSTAGE=5).
// Two instances: u_h1 (FLUSH_HOLD=1) and u_h3 (FLUSH_HOLD=3), same inputs.
// Directed vector table on u_h1, hand sequences for flush hold/widen, reset
// abort and the watchdog, then random traffic against a mode-level model.
module tb_pipe_ctrl;
    localparam int N = 5;
    localparam int RUN_M = 0, STALL_M = 1, FLUSH_M = 2;
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
    localparam int WD_CYC = 15;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] stall_req, release_req, flush_req;
    logic [N-1:0] stall1, flush1, stall3, flush3;
    logic         busy1, busy3, to1, to3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGE(N), .FLUSH_HOLD(1), .TIMEOUT_W(4)) u_h1 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .release_req(release_req),
        .flush_req(flush_req), .stall(stall1), .flush(flush1), .busy(busy1),
        .timeout(to1));

    pipe_ctrl #(.NSTAGE(N), .FLUSH_HOLD(3), .TIMEOUT_W(4)) u_h3 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .release_req(release_req),
        .flush_req(flush_req), .stall(stall3), .flush(flush3), .busy(busy3),
        .timeout(to3));

    // ---------------- reference model (mode level) ----------------
    typedef struct {
        int mode;   // RUN_M / STALL_M / FLUSH_M
        int src;    // stall owner index
        int fk;     // flush depth
        int left;   // flush cycles still to show
        int age;    // stall cycles shown so far, 1 on the first
        bit to;
    } mdl_t;

    mdl_t m1, m3;

    function automatic int hi(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [N-1:0] lowmask(input int n);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) if (i < n) r[i] = 1'b1;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic [N-1:0] s, r, f,
                                   input int hold);
        mdl_t n = m;
        int   k = hi(f);
        int   j = hi(s);
        bit   rel = 1'b0;
        n.to = 1'b0;
        for (int i = 0; i < N; i++) if (r[i] && i >= m.src) rel = 1'b1;
        if (k >= 1 && (m.mode != FLUSH_M || k > m.fk)) begin
            n.mode = FLUSH_M; n.fk = k; n.left = hold;
        end else if (m.mode == FLUSH_M) begin
            n.left = m.left - 1;
            if (n.left == 0) n.mode = RUN_M;
        end else if (m.mode == STALL_M) begin
            if (rel) n.mode = RUN_M;
            else if (j > m.src) begin n.src = j; n.age = 1; end
            else begin
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
                if (m.age == WD_CYC) begin n.mode = RUN_M; n.to = 1'b1; end
                else n.age = m.age + 1;
`endif
            end
        end else if (j >= 0) begin
            n.mode = STALL_M; n.src = j; n.age = 1;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk_dut(input string tag, input int d, input logic [N-1:0] es,
                           input logic [N-1:0] ef, input logic eb, input logic et);
        logic [N-1:0] s, f;
        logic b, t;
        s = (d == 1) ? stall1 : stall3;
        f = (d == 1) ? flush1 : flush3;
        b = (d == 1) ? busy1  : busy3;
        t = (d == 1) ? to1    : to3;
        tests += 5;
        if (s !== es) begin fails++; $display("FAIL %s stall: got %b expected %b", tag, s, es); end
        if (f !== ef) begin fails++; $display("FAIL %s flush: got %b expected %b", tag, f, ef); end
        if (b !== eb) begin fails++; $display("FAIL %s busy: got %b expected %b", tag, b, eb); end
        if (t !== et) begin fails++; $display("FAIL %s timeout: got %b expected %b", tag, t, et); end
        if ((s & f) !== '0) begin fails++; $display("FAIL %s overlap: got %b expected 00000", tag, s & f); end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] s, r, f);
        stall_req = s; release_req = r; flush_req = f;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive('0, '0, '0);
        #1;
        chk_dut({tag, "_h1"}, 1, '0, '0, 1'b0, 1'b0);
        chk_dut({tag, "_h3"}, 3, '0, '0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        m1 = '{default: 0};
        m3 = '{default: 0};
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] s, r, f;
        logic [N-1:0] es, ef;
        logic         eb;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mkv(input logic [N-1:0] s, r, f, es, ef, input logic eb);
        vec_t v;
        v.s = s; v.r = r; v.f = f; v.es = es; v.ef = ef; v.eb = eb;
        return v;
    endfunction

    initial begin
        logic [N-1:0] rs, rr, rf;

        tbl[0]  = mkv(5'b00010, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[1]  = mkv(5'b00000, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[2]  = mkv(5'b00000, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[3]  = mkv(5'b00000, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[4]  = mkv(5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tbl[5]  = mkv(5'b00010, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[6]  = mkv(5'b00000, 5'b00001, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[7]  = mkv(5'b00000, 5'b00010, 5'b00100, 5'b00000, 5'b00011, 1'b1);
        tbl[8]  = mkv(5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tbl[9]  = mkv(5'b00010, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[10] = mkv(5'b00100, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tbl[11] = mkv(5'b00100, 5'b00000, 5'b00000, 5'b00111, 5'b00000, 1'b1);
        tbl[12] = mkv(5'b01000, 5'b00000, 5'b00000, 5'b01111, 5'b00000, 1'b1);
        tbl[13] = mkv(5'b00010, 5'b00000, 5'b00000, 5'b01111, 5'b00000, 1'b1);
        tbl[14] = mkv(5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tbl[15] = mkv(5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
        tbl[16] = mkv(5'b00010, 5'b00000, 5'b00000, 5'b00011, 5'b00000, 1'b1);
        tbl[17] = mkv(5'b01000, 5'b00000, 5'b00000, 5'b01111, 5'b00000, 1'b1);
        tbl[18] = mkv(5'b00000, 5'b00100, 5'b00000, 5'b01111, 5'b00000, 1'b1);
        tbl[19] = mkv(5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tbl[20] = mkv(5'b11111, 5'b00000, 5'b10000, 5'b00000, 5'b01111, 1'b1);
        tbl[21] = mkv(5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tbl[22] = mkv(5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        do_reset("reset0");
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].s, tbl[i].r, tbl[i].f);
            step();
            chk_dut($sformatf("vec%0d", i), 1, tbl[i].es, tbl[i].ef, tbl[i].eb, 1'b0);
        end

        // Flush hold of 3 with a deeper flush on the second FLUSH cycle.
        do_reset("reset1");
        drive('0, '0, 5'b00100); step(); chk_dut("hold_c1", 3, '0, 5'b00011, 1'b1, 1'b0);
        drive('0, '0, '0);       step(); chk_dut("hold_c2", 3, '0, 5'b00011, 1'b1, 1'b0);
        drive('0, '0, 5'b01000); step(); chk_dut("widen_c1", 3, '0, 5'b00111, 1'b1, 1'b0);
        drive('0, '0, '0);       step(); chk_dut("widen_c2", 3, '0, 5'b00111, 1'b1, 1'b0);
        step();                          chk_dut("widen_c3", 3, '0, 5'b00111, 1'b1, 1'b0);
        step();                          chk_dut("widen_end", 3, '0, '0, 1'b0, 1'b0);
        // Equal and shallower flushes must not reload the hold.
        drive('0, '0, 5'b00100); step(); chk_dut("eq_c1", 3, '0, 5'b00011, 1'b1, 1'b0);
        drive('0, '0, 5'b00100); step(); chk_dut("eq_c2", 3, '0, 5'b00011, 1'b1, 1'b0);
        drive('0, '0, 5'b00010); step(); chk_dut("eq_c3", 3, '0, 5'b00011, 1'b1, 1'b0);
        drive('0, '0, '0);       step(); chk_dut("eq_end", 3, '0, '0, 1'b0, 1'b0);

        // Reset on STALL cycle 5 aborts immediately, nothing left afterwards.
        do_reset("reset2");
        drive(5'b00010, '0, '0); step();
        drive('0, '0, '0);
        repeat (4) step();
        chk_dut("stall_c5", 1, 5'b00011, '0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk_dut("rst_mid_stall", 1, '0, '0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step(); chk_dut("post_rst_stall", 1, '0, '0, 1'b0, 1'b0);

        // Reset in the middle of a 3-cycle flush.
        drive('0, '0, 5'b10000); step();
        drive('0, '0, '0);       step();
        chk_dut("flush_mid", 3, '0, 5'b01111, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk_dut("rst_mid_flush", 3, '0, '0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step(); chk_dut("post_rst_flush", 3, '0, '0, 1'b0, 1'b0);

        // Unreleased stall.
        do_reset("reset3");
        drive(5'b00010, '0, '0); step();
        drive('0, '0, '0);
`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
        chk_dut("wd_c1", 1, 5'b00011, '0, 1'b1, 1'b0);
        for (int c = 2; c <= 15; c++) begin
            step(); chk_dut($sformatf("wd_c%0d", c), 1, 5'b00011, '0, 1'b1, 1'b0);
        end
        step(); chk_dut("wd_fire", 1, '0, '0, 1'b0, 1'b1);
        step(); chk_dut("wd_after", 1, '0, '0, 1'b0, 1'b0);
`else
        for (int c = 1; c <= 40; c++) begin
            chk_dut($sformatf("hold_c%0d", c), 1, 5'b00011, '0, 1'b1, 1'b0);
            step();
        end
`endif

        // Random traffic against the model, both hold settings.
        do_reset("reset4");
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 99) < 20) ? N'($urandom_range(0, 31)) : '0;
            rr = ($urandom_range(0, 99) < 10) ? N'($urandom_range(0, 31)) : '0;
            rf = ($urandom_range(0, 99) < 6)  ? N'($urandom_range(0, 31)) : '0;
            drive(rs, rr, rf);
            step();
            m1 = mstep(m1, rs, rr, rf, 1);
            m3 = mstep(m3, rs, rr, rf, 3);
            chk_dut($sformatf("rand%0d_h1", n), 1,
                    (m1.mode == STALL_M) ? lowmask(m1.src + 1) : '0,
                    (m1.mode == FLUSH_M) ? lowmask(m1.fk) : '0,
                    m1.mode != RUN_M, m1.to);
            chk_dut($sformatf("rand%0d_h3", n), 3,
                    (m3.mode == STALL_M) ? lowmask(m3.src + 1) : '0,
                    (m3.mode == FLUSH_M) ? lowmask(m3.fk) : '0,
                    m3.mode != RUN_M, m3.to);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter NSTAGE, default 5: number of pipeline stages; index 0 is the youngest stage (fetch) and NSTAGE-1 the oldest.
REQ-002 The block SHALL have parameter FLUSH_HOLD, default 1: number of cycles a flush is asserted, legal range 1..15.
REQ-003 The block SHALL have parameter TIMEOUT_W, default 4: width of the stall watchdog counter.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port stall_req, input, NSTAGE bits: per-stage pause request.
REQ-007 The block SHALL have port release_req, input, NSTAGE bits: per-stage unpause request.
REQ-008 The block SHALL have port flush_req, input, NSTAGE bits: per-stage flush request.
REQ-009 The block SHALL have port stall, output, NSTAGE bits, registered: per-stage hold command.
REQ-010 The block SHALL have port flush, output, NSTAGE bits, registered: per-stage flush command.
REQ-011 The block SHALL have port busy, output, 1 bit, registered: high whenever the state is not RUN.
REQ-012 The block SHALL have port timeout, output, 1 bit, registered: one-cycle watchdog pulse.

Function
REQ-013 The block SHALL implement a state machine with three states: RUN, STALL and FLUSH.
REQ-014 All outputs SHALL be registered, with one-cycle latency from request to command.
REQ-015 Request priority SHALL be flush_req, then release_req, then stall_req.
REQ-016 Let k be the highest set index of flush_req with k>=1: the block SHALL drive flush bits 0..k-1 high, drive all stall bits low, enter FLUSH and load the hold counter with FLUSH_HOLD-1, from any state.
REQ-017 flush_req with only bit 0 set SHALL be a no-op.
REQ-018 In FLUSH, when the counter is 0, the block SHALL return to RUN and clear flush; otherwise it SHALL decrement the counter.
REQ-019 In FLUSH, a new flush_req with a higher k SHALL widen the mask and reload the counter; an equal or lower k SHALL be ignored.
REQ-020 stall_req and release_req SHALL be ignored in FLUSH.
REQ-021 In RUN, let j be the highest set bit of stall_req: the block SHALL drive stall bits 0..j high, record src=j and enter STALL.
REQ-022 The stall SHALL be sticky: it is held until released.
REQ-023 In STALL, any release_req bit at an index >= src SHALL return the block to RUN with stall cleared.
REQ-024 In STALL, release_req bits at indices below src SHALL be ignored.
REQ-025 In STALL, a stall_req with j > src SHALL widen the mask to 0..j and set src=j.
REQ-026 If release_req and stall_req arrive in the same cycle, release SHALL win; a still-asserted stall_req re-stalls on the following cycle.
REQ-027 busy SHALL equal (state != RUN).
REQ-028 flush and stall SHALL never both be high for the same stage in the same cycle.

Reset
REQ-029 On rst, the block SHALL asynchronously set state=RUN and clear stall, flush, busy, timeout, src, the hold counter and the watchdog counter.
REQ-030 Reset asserted mid-STALL or mid-FLUSH SHALL abort the operation with no residual pulse after deassertion.
REQ-031 The first state update SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-032 When PIPE_CTRL_STALL_TIMEOUT_EN is defined, a TIMEOUT_W-bit watchdog SHALL count cycles spent in STALL, starting from 0 on entry and resetting on widen.
REQ-033 With PIPE_CTRL_STALL_TIMEOUT_EN defined, when the watchdog reaches 2^TIMEOUT_W-1 the block SHALL force RUN, clear stall and pulse timeout for one cycle; flush and release take priority over the timeout in the same cycle.
REQ-034 When PIPE_CTRL_STALL_TIMEOUT_EN is undefined, timeout SHALL be tied to 0, no watchdog logic SHALL exist, and a stall SHALL be held indefinitely.

Verification
REQ-035 Stall/release: NSTAGE=5; stall_req=00010 for one cycle, then idle 3 cycles, then release_req=00010 -> stall=00011 from cycle+1 through the release cycle, stall=00000 and busy=0 one cycle after release.
REQ-036 Flush priority: in STALL with src=1, flush_req=00100 and release_req=00010 in the same cycle -> next cycle flush=00011, stall=00000, busy=1; with FLUSH_HOLD=1, one cycle later flush=00000 and busy=0.
REQ-037 Flush hold and widen: FLUSH_HOLD=3; flush_req=00100, then flush_req=01000 on the second FLUSH cycle -> flush=00011 for 2 cycles, then flush=00111 for 3 more cycles, then 00000.
REQ-038 Simultaneous release/stall and widen: in STALL with src=1, release_req=00010 and stall_req=00100 together -> one RUN cycle, then stall=00111 if stall_req is still held; separately, stall_req=01000 while src=1 -> stall=01111.
REQ-039 Watchdog and reset: with the macro defined and TIMEOUT_W=4, a stall that is never released -> stall clears and timeout=1 for exactly one cycle after 15 STALL cycles; asserting rst on STALL cycle 5 -> all outputs 0 immediately.
